pref_req_queue: RTL and testbench

//  Downstream of the IP-stride prefetcher. Accepts up to 3 prefetch candidates
//  per cycle (pref_addr1..3 / pref_valid1..3). Aligns each one to a cache line
//  and optionally removes duplicates. Buffers accepted lines in a circular FIFO
//  and issues them one per cycle to the L2/memory port over a valid/ready

---
 rtl/pref_req_queue.sv | 118 +++++++++++
 tb/tb_pref_req_queue.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pref_req_queue.sv
// Prefetch request queue: aligns up to 3 candidates/cycle to cache lines, dedups, buffers and issues one per cycle.
// Optional macro PREF_QUEUE_DEDUP_EN also drops candidates already held in the FIFO.
module pref_req_queue #(
  parameter int DEPTH           = 8,
  parameter int ADDR_SIZE       = 64,
  parameter int LOG2_BLOCK_SIZE = 6,
  parameter int CNT_W           = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_SIZE-1:0]       pref_addr1_i,
  input  logic                       pref_valid1_i,
  input  logic [ADDR_SIZE-1:0]       pref_addr2_i,
  input  logic                       pref_valid2_i,
  input  logic [ADDR_SIZE-1:0]       pref_addr3_i,
  input  logic                       pref_valid3_i,
  output logic [ADDR_SIZE-1:0]       req_addr_o,
  output logic                       req_valid_o,
  input  logic                       req_ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic [CNT_W-1:0]           drop_cnt_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = ADDR_SIZE - LOG2_BLOCK_SIZE;

  logic [LW-1:0]    mem [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count;
  logic [CNT_W-1:0] drop_cnt;

  logic [LW-1:0]    la1, la2, la3;
  logic [2:0]       hit, surv, acc, dropped;
  logic             pop;
  logic [CW-1:0]    free, n_acc;
  logic [1:0]       n_drop;
  logic [CNT_W:0]   drop_sum;
  logic [PW-1:0]    w2, w3;

  assign la1 = pref_addr1_i[ADDR_SIZE-1:LOG2_BLOCK_SIZE];
  assign la2 = pref_addr2_i[ADDR_SIZE-1:LOG2_BLOCK_SIZE];
  assign la3 = pref_addr3_i[ADDR_SIZE-1:LOG2_BLOCK_SIZE];

`ifdef PREF_QUEUE_DEDUP_EN
  logic [DEPTH-1:0] occ;
  logic [PW-1:0]    rel;

  // Compare against registered contents only, including a head popped this cycle.
  always_comb begin
    occ = '0;
    rel = '0;
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel    = PW'(i) - head;
      occ[i] = ({1'b0, rel} < count);
      if (occ[i]) begin
        if (mem[i] == la1) hit[0] = 1'b1;
        if (mem[i] == la2) hit[1] = 1'b1;
        if (mem[i] == la3) hit[2] = 1'b1;
      end
    end
  end
`else
  assign hit = '0;
`endif

  always_comb begin
    surv[0] = pref_valid1_i & ~hit[0];
    surv[1] = pref_valid2_i & ~(pref_valid1_i && (la2 == la1)) & ~hit[1];
    surv[2] = pref_valid3_i & ~(pref_valid1_i && (la3 == la1))
                            & ~(pref_valid2_i && (la3 == la2)) & ~hit[2];

    pop  = (count != '0) && req_ready_i;
    free = CW'(DEPTH) - count + CW'(pop);

    // Lower-priority survivors only get whatever space the higher ones left.
    acc[0] = surv[0] && (free > CW'(0));
    acc[1] = surv[1] && (free > CW'(acc[0]));
    acc[2] = surv[2] && (free > (CW'(acc[0]) + CW'(acc[1])));

    n_acc   = CW'(acc[0]) + CW'(acc[1]) + CW'(acc[2]);
    dropped = surv & ~acc;
    n_drop  = 2'(dropped[0]) + 2'(dropped[1]) + 2'(dropped[2]);
    drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(n_drop);

    w2 = tail + PW'(acc[0]);
    w3 = w2 + PW'(acc[1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (pop) head <= head + PW'(1);
      tail     <= tail + PW'(n_acc);
      count    <= count - CW'(pop) + n_acc;
      drop_cnt <= drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (acc[0]) mem[tail] <= la1;
      if (acc[1]) mem[w2]   <= la2;
      if (acc[2]) mem[w3]   <= la3;
    end
  end

  assign req_valid_o = (count != '0);
  assign req_addr_o  = req_valid_o ? {mem[head], {LOG2_BLOCK_SIZE{1'b0}}} : '0;
  assign count_o     = count;
  assign full_o      = (count == CW'(DEPTH));
  assign drop_cnt_o  = drop_cnt;
endmodule

// File: tb/tb_pref_req_queue.sv
// Directed bench for pref_req_queue with hand-computed expectations (DEPTH=8, 64-byte lines).
module tb_pref_req_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pref_addr1_i, pref_addr2_i, pref_addr3_i;
  logic        pref_valid1_i, pref_valid2_i, pref_valid3_i;
  logic [63:0] req_addr_o;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [3:0]  count_o;
  logic        full_o;
  logic [15:0] drop_cnt_o;

  int checks = 0;
  int errors = 0;

  pref_req_queue dut (
    .clk(clk), .rst(rst),
    .pref_addr1_i(pref_addr1_i), .pref_valid1_i(pref_valid1_i),
    .pref_addr2_i(pref_addr2_i), .pref_valid2_i(pref_valid2_i),
    .pref_addr3_i(pref_addr3_i), .pref_valid3_i(pref_valid3_i),
    .req_addr_o(req_addr_o), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .count_o(count_o), .full_o(full_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v1, input logic [63:0] a1,
                       input logic v2, input logic [63:0] a2,
                       input logic v3, input logic [63:0] a3);
    pref_valid1_i = v1; pref_addr1_i = a1;
    pref_valid2_i = v2; pref_addr2_i = a2;
    pref_valid3_i = v3; pref_addr3_i = a3;
  endtask

  task automatic idle();
    offer(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
  endtask

  task automatic drain(input string tag);
    int n;
    idle();
    req_ready_i = 1'b1;
    n = 0;
    while (count_o != 4'd0 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (count_o !== 4'd0) begin
      errors++;
      $display("FAIL drain_%s: count=%0d after %0d cycles, required 0", tag, count_o, n);
    end
    req_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_ready_i = 1'b0; idle();
    step(); step();
    rst = 1'b0;
    checks++;
    if (count_o !== 4'd0 || req_valid_o !== 1'b0 || full_o !== 1'b0 ||
        drop_cnt_o !== 16'd0 || req_addr_o !== 64'h0) begin
      errors++;
      $display("FAIL reset: count=%0d valid=%0b full=%0b drop=%0d addr=%h, required 0/0/0/0/0",
               count_o, req_valid_o, full_o, drop_cnt_o, req_addr_o);
    end
  endtask

  task automatic test_single();
    req_ready_i = 1'b1;
    offer(1'b1, 64'h1040, 1'b0, 64'h0, 1'b0, 64'h0);
    step();
    idle();
    checks++;
    if (req_valid_o !== 1'b1 || req_addr_o !== 64'h1040 || count_o !== 4'd1) begin
      errors++;
      $display("FAIL single_issue: valid=%0b addr=%h count=%0d, required 1/1040/1",
               req_valid_o, req_addr_o, count_o);
    end
    step();
    checks++;
    if (count_o !== 4'd0 || req_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_pop: count=%0d valid=%0b, required 0/0", count_o, req_valid_o);
    end
    req_ready_i = 1'b0;
  endtask

  task automatic test_order();
    logic [63:0] exp_addr [3];
    exp_addr[0] = 64'h2000; exp_addr[1] = 64'h2040; exp_addr[2] = 64'h2080;
    req_ready_i = 1'b0;
    offer(1'b1, 64'h2000, 1'b1, 64'h2040, 1'b1, 64'h2080);
    step();
    idle();
    checks++;
    if (count_o !== 4'd3) begin
      errors++;
      $display("FAIL order_count: count=%0d, required 3", count_o);
    end
    req_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (req_valid_o !== 1'b1 || req_addr_o !== exp_addr[i]) begin
        errors++;
        $display("FAIL order_issue%0d: valid=%0b addr=%h, required 1/%h",
                 i, req_valid_o, req_addr_o, exp_addr[i]);
      end
      step();
    end
    checks++;
    if (count_o !== 4'd0 || req_addr_o !== 64'h0) begin
      errors++;
      $display("FAIL order_empty: count=%0d addr=%h, required 0/0", count_o, req_addr_o);
    end
    req_ready_i = 1'b0;
  endtask

  task automatic test_intra_dedup();
    req_ready_i = 1'b0;
    offer(1'b1, 64'h3000, 1'b1, 64'h3010, 1'b1, 64'h3040);
    step();
    idle();
    checks++;
    if (count_o !== 4'd2 || drop_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL intra_dedup: count=%0d drop=%0d, required 2/0", count_o, drop_cnt_o);
    end
    checks++;
    if (req_addr_o !== 64'h3000) begin
      errors++;
      $display("FAIL intra_dedup_head: addr=%h, required 3000", req_addr_o);
    end
    drain("intra");
  endtask

  task automatic test_full();
    req_ready_i = 1'b0;
    offer(1'b1, 64'h5000, 1'b1, 64'h5040, 1'b1, 64'h5080); step();
    offer(1'b1, 64'h50c0, 1'b1, 64'h5100, 1'b1, 64'h5140); step();
    offer(1'b1, 64'h5180, 1'b0, 64'h0,    1'b0, 64'h0);    step();
    idle();
    checks++;
    if (count_o !== 4'd7 || full_o !== 1'b0) begin
      errors++;
      $display("FAIL fill7: count=%0d full=%0b, required 7/0", count_o, full_o);
    end
    offer(1'b1, 64'h6000, 1'b1, 64'h6040, 1'b1, 64'h6080);
    step();
    idle();
    checks++;
    if (count_o !== 4'd8 || full_o !== 1'b1 || drop_cnt_o !== 16'd2) begin
      errors++;
      $display("FAIL overflow: count=%0d full=%0b drop=%0d, required 8/1/2",
               count_o, full_o, drop_cnt_o);
    end
    req_ready_i = 1'b1;
    offer(1'b1, 64'h7000, 1'b0, 64'h0, 1'b0, 64'h0);
    step();
    idle();
    req_ready_i = 1'b0;
    checks++;
    if (count_o !== 4'd8 || full_o !== 1'b1 || drop_cnt_o !== 16'd2 || req_addr_o !== 64'h5040) begin
      errors++;
      $display("FAIL full_pop_push: count=%0d full=%0b drop=%0d addr=%h, required 8/1/2/5040",
               count_o, full_o, drop_cnt_o, req_addr_o);
    end
    // Walk the wrapped contents to confirm the recycled slot holds the late candidate.
    req_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (req_addr_o !== 64'h6000) begin
      errors++;
      $display("FAIL wrap_seq6000: addr=%h, required 6000", req_addr_o);
    end
    step();
    checks++;
    if (req_addr_o !== 64'h7000 || count_o !== 4'd1) begin
      errors++;
      $display("FAIL wrap_seq7000: addr=%h count=%0d, required 7000/1", req_addr_o, count_o);
    end
    drain("full");
  endtask

  task automatic test_fifo_dedup();
    logic [3:0] exp_cnt;
`ifdef PREF_QUEUE_DEDUP_EN
    exp_cnt = 4'd1;
`else
    exp_cnt = 4'd2;
`endif
    req_ready_i = 1'b0;
    offer(1'b1, 64'h4000, 1'b0, 64'h0, 1'b0, 64'h0);
    step();
    offer(1'b1, 64'h4000, 1'b1, 64'h4020, 1'b0, 64'h0);
    step();
    idle();
    checks++;
    if (count_o !== exp_cnt || drop_cnt_o !== 16'd2) begin
      errors++;
      $display("FAIL fifo_dedup: count=%0d drop=%0d, required %0d/2", count_o, drop_cnt_o, exp_cnt);
    end
    drain("dedup");
  endtask

  task automatic test_stall_reset();
    req_ready_i = 1'b0;
    offer(1'b1, 64'h8000, 1'b1, 64'h8040, 1'b0, 64'h0);
    step();
    idle();
    checks++;
    if (count_o !== 4'd2) begin
      errors++;
      $display("FAIL stall_count: count=%0d, required 2", count_o);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (req_valid_o !== 1'b1 || req_addr_o !== 64'h8000) begin
        errors++;
        $display("FAIL stall_hold%0d: valid=%0b addr=%h, required 1/8000", i, req_valid_o, req_addr_o);
      end
    end
    rst = 1'b1;
    req_ready_i = 1'b1;
    offer(1'b1, 64'h9000, 1'b1, 64'h9040, 1'b1, 64'h9080);
    step();
    rst = 1'b0;
    idle();
    req_ready_i = 1'b0;
    checks++;
    if (count_o !== 4'd0 || req_valid_o !== 1'b0 || drop_cnt_o !== 16'd0 || req_addr_o !== 64'h0) begin
      errors++;
      $display("FAIL mid_reset: count=%0d valid=%0b drop=%0d addr=%h, required 0/0/0/0",
               count_o, req_valid_o, drop_cnt_o, req_addr_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_intra_dedup();
    test_full();
    test_fifo_dedup();
    test_stall_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
